// File: rtl/tile_raster_collector.sv
// Collects 3x12 filter-core tiles into a two-bank band buffer and drains it
// in raster order, one 12-pixel row segment per beat, with line/frame markers.
`timescale 1ns/1ps

module tile_raster_collector #(
    parameter int PIX_W         = 8,
    parameter int TILE_W        = 12,
    parameter int TILE_H        = 3,
    parameter int TILES_PER_ROW = 53,
    parameter int BANDS         = 160
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PIX_W*TILE_W*TILE_H-1:0]  in_tile,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PIX_W*TILE_W-1:0]         out_data,
    output logic                            out_eol,
    output logic                            out_eof
);

    localparam int SEG_W     = PIX_W * TILE_W;
    localparam int TILE_BITS = SEG_W * TILE_H;
    localparam int TW        = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
    localparam int RW        = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int BW        = (BANDS > 1) ? $clog2(BANDS) : 1;

    localparam logic [TW-1:0] LAST_TILE = TW'(TILES_PER_ROW - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(TILE_H - 1);
    localparam logic [BW-1:0] LAST_BAND = BW'(BANDS - 1);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    bank_state_t bank_state      [2];
    bank_state_t bank_state_next [2];
    logic [1:0]  full;

    logic          wbank;
    logic          rbank;
    logic [TW-1:0] wtile;
    logic [TW-1:0] rtile;
    logic [RW-1:0] rrow;
    logic [BW-1:0] band_cnt;

    logic [SEG_W-1:0] mem [2][TILE_H][TILES_PER_ROW];

    logic wr_fire;
    logic wr_last;
    logic rd_fire;
    logic rd_row_end;
    logic rd_last;

    assign full[0] = (bank_state[0] == BANK_FULL);
    assign full[1] = (bank_state[1] == BANK_FULL);

    assign in_ready   = !full[wbank] && !rst;
    assign out_valid  = full[rbank];
    assign out_data   = out_valid ? mem[rbank][rrow][rtile] : '0;
    assign out_eol    = out_valid && rd_row_end;
    assign out_eof    = out_eol && (rrow == LAST_ROW) && (band_cnt == LAST_BAND);

    assign wr_fire    = in_valid && in_ready;
    assign wr_last    = wr_fire && (wtile == LAST_TILE);
    assign rd_fire    = out_valid && out_ready;
    assign rd_row_end = (rtile == LAST_TILE);
    assign rd_last    = rd_fire && rd_row_end && (rrow == LAST_ROW);

    // Writer and reader always own different banks, so a fill and a release
    // in the same cycle touch different entries and both take effect.
    always_comb begin
        bank_state_next[0] = bank_state[0];
        bank_state_next[1] = bank_state[1];
        if (wr_last) bank_state_next[wbank] = BANK_FULL;
        if (rd_last) bank_state_next[rbank] = BANK_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            bank_state[0] <= bank_state_next[0];
            bank_state[1] <= bank_state_next[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank <= 1'b0;
            wtile <= '0;
        end else if (wr_fire) begin
            if (wtile == LAST_TILE) begin
                wtile <= '0;
                wbank <= ~wbank;
            end else begin
                wtile <= wtile + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbank    <= 1'b0;
            rtile    <= '0;
            rrow     <= '0;
            band_cnt <= '0;
        end else if (rd_fire) begin
            if (rd_row_end) begin
                rtile <= '0;
                if (rrow == LAST_ROW) begin
                    rrow     <= '0;
                    rbank    <= ~rbank;
                    band_cnt <= (band_cnt == LAST_BAND) ? '0 : band_cnt + 1'b1;
                end else begin
                    rrow <= rrow + 1'b1;
                end
            end else begin
                rtile <= rtile + 1'b1;
            end
        end
    end

    // Pixel storage needs no reset; out_valid gates everything read from it.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < TILE_H; k++) begin
                mem[wbank][k][wtile] <= in_tile[TILE_BITS-1-k*SEG_W -: SEG_W];
            end
        end
    end

endmodule

// File: tb/tb_tile_raster_collector.sv
// Directed bench for tile_raster_collector: drives tiles and checks each
// output beat against expected raster order, markers and throttling.
`timescale 1ns/1ps

module tb_tile_raster_collector;

    localparam int TPR            = 53;
    localparam int BANDS          = 160;
    localparam int BEATS_PER_BAND = 159;
    localparam int FRAME_TILES    = TPR * BANDS;
    localparam int FRAME_BEATS    = BEATS_PER_BAND * BANDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [287:0] in_tile;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  out_data;
    logic         out_eol;
    logic         out_eof;

    always #5 clk = ~clk;

    tile_raster_collector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tile   (in_tile),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    int checks   = 0;
    int failures = 0;

    int sent, beats, beat_in_band, band_in_frame, cyc;
    int eol_seen, eof_seen, first_eof_beat, second_eof_beat, stalls;
    logic [7:0]  salt;
    bit          col_mix;
    bit          prev_stall;
    logic [95:0] prev_data;
    logic        prev_eol, prev_eof;
    bit          acc_now, hs_now;
    logic        obs_in_ready;

    task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] pix(int k, int t, int j);
        logic [7:0] base;
        base = {k[1:0], t[5:0]} ^ salt;
        return col_mix ? base + 8'(j) : base;
    endfunction

    function automatic logic [287:0] makeTile(int t);
        logic [287:0] r;
        r = '0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 12; j++)
                r[287-8*(12*k+j) -: 8] = pix(k, t, j);
        return r;
    endfunction

    function automatic logic [95:0] expSeg(int k, int t);
        logic [95:0] r;
        r = '0;
        for (int j = 0; j < 12; j++) r[95-8*j -: 8] = pix(k, t, j);
        return r;
    endfunction

    // One clock of stimulus plus scoreboard update for whatever handshakes occur.
    task automatic applyStimulus(input bit want_valid, input bit rdy);
        bit exp_eol, exp_eof;
        @(negedge clk);
        in_valid  = want_valid;
        in_tile   = makeTile(sent % TPR);
        out_ready = rdy;
        #1;
        obs_in_ready = in_ready;
        if (prev_stall) begin
            checkOutput("stall_valid", 96'(out_valid), 96'(1));
            checkOutput("stall_data", out_data, prev_data);
            checkOutput("stall_eol", 96'(out_eol), 96'(prev_eol));
            checkOutput("stall_eof", 96'(out_eof), 96'(prev_eof));
        end
        if (!out_valid) begin
            checkOutput("idle_data", out_data, 96'(0));
            checkOutput("idle_markers", 96'({out_eol, out_eof}), 96'(0));
        end
        acc_now = in_valid && in_ready;
        if (acc_now) sent++;
        hs_now = out_valid && out_ready;
        if (hs_now) begin
            exp_eol = (beat_in_band % TPR) == TPR - 1;
            exp_eof = (beat_in_band == BEATS_PER_BAND - 1) && (band_in_frame == BANDS - 1);
            checkOutput("beat_data", out_data, expSeg(beat_in_band / TPR, beat_in_band % TPR));
            checkOutput("beat_eol", 96'(out_eol), 96'(exp_eol));
            checkOutput("beat_eof", 96'(out_eof), 96'(exp_eof));
            beats++;
            if (out_eol) eol_seen++;
            if (out_eof) begin
                eof_seen++;
                if (eof_seen == 1) first_eof_beat = beats;
                if (eof_seen == 2) second_eof_beat = beats;
            end
            beat_in_band++;
            if (beat_in_band == BEATS_PER_BAND) begin
                beat_in_band = 0;
                band_in_frame = (band_in_frame == BANDS - 1) ? 0 : band_in_frame + 1;
            end
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) stalls++;
        prev_data = out_data;
        prev_eol  = out_eol;
        prev_eof  = out_eof;
        cyc++;
    endtask

    task automatic resetDut(input int n);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_tile   = makeTile(5);
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput("rst_in_ready", 96'(in_ready), 96'(0));
            checkOutput("rst_out_valid", 96'(out_valid), 96'(0));
            checkOutput("rst_out_data", out_data, 96'(0));
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 96'(in_ready), 96'(1));
        checkOutput("post_rst_out_valid", 96'(out_valid), 96'(0));
        sent = 0; beats = 0; beat_in_band = 0; band_in_frame = 0; cyc = 0;
        eol_seen = 0; eof_seen = 0; first_eof_beat = 0; second_eof_beat = 0; stalls = 0;
        prev_stall = 1'b0;
    endtask

    initial begin
        int last_acc, first_hs, acc106, drop;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tile = '0;
        salt = 8'h00; col_mix = 1'b0;

        // Single band with free-running output.
        resetDut(2);
        last_acc = -1; first_hs = -1;
        while ((sent < TPR || beats < BEATS_PER_BAND) && cyc < 400) begin
            applyStimulus(sent < TPR, 1'b1);
            if (acc_now && sent == TPR) last_acc = cyc - 1;
            if (hs_now && first_hs < 0) first_hs = cyc - 1;
        end
        checkOutput("band_beats", 96'(beats), 96'(BEATS_PER_BAND));
        checkOutput("band_latency", 96'(first_hs - last_acc), 96'(1));
        checkOutput("band_eol_count", 96'(eol_seen), 96'(3));
        checkOutput("band_eof_count", 96'(eof_seen), 96'(0));
        repeat (3) applyStimulus(1'b0, 1'b1);
        checkOutput("band_drained", 96'(out_valid), 96'(0));

        // Backpressure: both banks fill, then free one by draining.
        salt = 8'h3C; col_mix = 1'b1;
        resetDut(2);
        acc106 = -1; drop = -1;
        repeat (130) begin
            applyStimulus(1'b1, 1'b0);
            if (acc_now && sent == 2 * TPR) acc106 = cyc - 1;
            if (!obs_in_ready && drop < 0) drop = cyc - 1;
        end
        checkOutput("bp_accepts", 96'(sent), 96'(2 * TPR));
        checkOutput("bp_drop_cycle", 96'(drop - acc106), 96'(1));
        checkOutput("bp_no_output", 96'(beats), 96'(0));
        while (beats < BEATS_PER_BAND && cyc < 400) applyStimulus(1'b1, 1'b1);
        checkOutput("bp_ready_at_last_read", 96'(obs_in_ready), 96'(0));
        applyStimulus(1'b1, 1'b1);
        checkOutput("bp_ready_after_free", 96'(obs_in_ready), 96'(1));
        while ((sent < 3 * TPR || beats < 3 * BEATS_PER_BAND) && cyc < 1000)
            applyStimulus(sent < 3 * TPR, 1'b1);
        checkOutput("bp_total_beats", 96'(beats), 96'(3 * BEATS_PER_BAND));

        // Output ready toggling every cycle.
        salt = 8'h55; col_mix = 1'b1;
        resetDut(2);
        while ((sent < TPR || beats < BEATS_PER_BAND) && cyc < 800)
            applyStimulus(sent < TPR, (cyc % 2) == 1);
        checkOutput("toggle_beats", 96'(beats), 96'(BEATS_PER_BAND));
        checkOutput("toggle_stalls_seen", 96'(stalls > 0), 96'(1));

        // Two complete frames.
        salt = 8'h00; col_mix = 1'b0;
        resetDut(2);
        while ((sent < 2 * FRAME_TILES || beats < 2 * FRAME_BEATS) && cyc < 60000)
            applyStimulus(sent < 2 * FRAME_TILES, 1'b1);
        checkOutput("frame_beats", 96'(beats), 96'(2 * FRAME_BEATS));
        checkOutput("frame_eof_count", 96'(eof_seen), 96'(2));
        checkOutput("frame_first_eof", 96'(first_eof_beat), 96'(FRAME_BEATS));
        checkOutput("frame_second_eof", 96'(second_eof_beat - first_eof_beat), 96'(FRAME_BEATS));

        // Reset in the middle of a band discards the partial fill.
        salt = 8'h11; col_mix = 1'b1;
        resetDut(2);
        repeat (20) applyStimulus(1'b1, 1'b1);
        checkOutput("mid_partial_accepts", 96'(sent), 96'(20));
        salt = 8'hA5;
        resetDut(1);
        while ((sent < TPR || beats < BEATS_PER_BAND) && cyc < 400)
            applyStimulus(sent < TPR, 1'b1);
        checkOutput("mid_fresh_beats", 96'(beats), 96'(BEATS_PER_BAND));
        repeat (5) applyStimulus(1'b0, 1'b1);
        checkOutput("mid_no_extra", 96'(out_valid), 96'(0));
        checkOutput("mid_total_beats", 96'(beats), 96'(BEATS_PER_BAND));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_raster_collector.md
Name: tile_raster_collector

Overview:
- Receives the 3-row x 12-column denoised output tiles (36 pixels per beat) from the filter core.
- Reorders them into raster order, one 12-pixel row segment per beat, with line and frame markers.
- Sits between the filter core's output and the downstream frame writer.
- Uses a two-bank band buffer so one band fills while the other drains; throttles the core with in_ready.

Parameters:
- PIX_W, 8, bits per pixel
- TILE_W, 12, pixels per tile row
- TILE_H, 3, rows per tile (rows per band)
- TILES_PER_ROW, 53, tiles across one band (636 output columns)
- BANDS, 160, bands per frame (480 output rows)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_tile holds a tile
- in_ready  output  1  block accepts a tile this cycle
- in_tile  input  PIX_W*TILE_W*TILE_H (288)  tile data
  - row k, col j at bits [287-8*(12k+j) -: 8]
  - row 0 in the MSBs, leftmost pixel in the MSBs
- out_valid  output  1  out_data holds a segment
- out_ready  input  1  downstream accepts
- out_data  output  PIX_W*TILE_W (96)  one row segment, leftmost pixel at [95:88]
- out_eol  output  1  last segment of an output row
- out_eof  output  1  last segment of the frame

Behaviour:
- Reset: rst is sampled at the clk edge.
  - Cleared: wbank, wtile, rbank, rrow, rtile, band_cnt, full[1:0].
  - Outputs: out_valid=0, out_eol=0, out_eof=0, out_data=0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
- Storage: bank[2] x row[3] x tile[53] x 96 bits.
- Bank state machine: each bank is EMPTY or FULL, held in a registered full[b].
- Write side:
  - in_ready = !full[wbank] && !rst.
  - An accept (in_valid && in_ready) writes the 3 row segments of in_tile to bank[wbank] at tile index wtile.
  - Then wtile increments.
  - On an accept with wtile==52: wtile<=0, full[wbank]<=1, wbank toggles.
- Upstream protocol: upstream holds in_tile stable while in_valid && !in_ready. A non-accepted beat is never written.
- Read side:
  - out_valid = full[rbank].
  - out_data = bank[rbank].row[rrow].tile[rtile] when out_valid=1, otherwise 0.
  - out_eol = out_valid && rtile==52.
  - out_eof = out_eol && rrow==2 && band_cnt==BANDS-1.
- Read pointer advance on each handshake (out_valid && out_ready):
  - rtile increments.
  - At rtile==52: rtile<=0, rrow increments.
  - At rrow==2 && rtile==52: rrow<=0, full[rbank]<=0, rbank toggles, band_cnt increments.
  - band_cnt wraps to 0 after the out_eof handshake.
- Stall: while out_valid && !out_ready, out_data, out_eol and out_eof hold stable.
- Latency: first out_valid is 1 cycle after the accept of tile 52 of a band (full is registered).
  - With both banks empty, that band's first segment appears the next cycle.
- Freed bank: a bank released by the last read handshake raises in_ready the following cycle, not the same cycle.
- Simultaneous write and read: always to different banks, so no conflict.
  - Simultaneous set and clear of different full bits are both honoured.
- Throughput:
  - Input: 1 tile/cycle until both banks are full.
  - Output: 159 beats per band; steady state is output-bound.
- Both banks full: in_ready=0 until the drain of rbank completes.
- Reset mid-operation: all partial band data is discarded. The next accepted tile is tile 0 of band 0 in bank 0.
- No arithmetic on pixel data. All counters are unsigned with explicit wrap values as above.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1.
  - During reset: in_ready=0, out_valid=0, out_data=0.
  - Cycle after: in_ready=1, and no tile was written.
- Single band, out_ready=1: 53 tiles where every pixel of tile t row k = {k[1:0],t[5:0]}.
  - 159 beats, row-major order; beat 53k+t has all bytes = {k,t}.
  - out_eol high on beats 52, 105 and 158 only; out_eof stays 0.
- Backpressure: out_ready=0, in_valid=1 continuously.
  - in_ready drops the cycle after the 106th accept, and no 107th accept occurs.
  - Raise out_ready: in_ready returns 1 cycle after the 159th read handshake.
- Stall stability: out_ready toggles every cycle during a band.
  - out_data/out_eol never change while out_valid && !out_ready.
  - Sequence is identical to the single-band case.
- Full frame: 8480 tiles with out_ready=1.
  - 25440 beats, out_eof asserted exactly once, on the final beat.
  - A second frame's out_eof lands again on beat 25440.
- Reset mid-band: accept 20 tiles, pulse rst for 1 cycle, then send 53 fresh tiles.
  - Output contains only the fresh band's data, read from bank 0.
